// File: rtl/spy_event_controller_pkg.sv
// spy_pkg: shared definitions for the spy event controller.
//   - SOE_CODE_DEFAULT : marker byte that tags a start-of-event word
//   - state_t          : controller state encoding
//   - META_* offsets   : layout of an event list entry {sentinel, addr}
package spy_pkg;

    localparam logic [7:0] SOE_CODE_DEFAULT = 8'hB0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_ARMED     = 3'd2,
        ST_LOOP_MARK = 3'd3,
        ST_FROZEN    = 3'd4
    } state_t;

    // Event list entry: address field occupies [memwidth-1:0], the wrap
    // sentinel flag sits directly above it.
    localparam int META_ADDR_LSB = 0;

    function automatic int meta_sentinel_bit(input int memwidth);
        return memwidth;
    endfunction

endpackage

// File: rtl/spy_event_controller_ram.sv
// spy_ram: simple dual-port RAM, one write port and one registered read port.
//   clock, reset          : clock, async active-low reset (read register only)
//   write_enable/addr/data: synchronous write port
//   read_enable/addr      : read strobe; read_data updates one edge later and
//                           holds while the strobe is low
// Array contents are not reset.
module spy_ram
    import spy_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [ADDRWIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]     write_data,
    input  logic                 read_enable,
    input  logic [ADDRWIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]     read_data
);

    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) mem[write_addr] <= write_data;
    end

    // Read-during-write to the same address returns the old word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           read_data <= '0;
        else if (read_enable) read_data <= mem[read_addr];
    end

endmodule

// File: rtl/spy_event_controller.sv
// spy_event_controller: captures a tagged data stream into a circular spy
// memory and keeps an event list of SOE addresses and wrap sentinels.
//   clock, reset               : clock, async active-low reset
//   freeze_req                 : level request to stop capture
//   postfreeze_count           : words still captured after a freeze request
//   data_in, write_enable_in   : capture stream (bit DATAWIDTH = metadata flag)
//   read_addr/enable, data_out : spy memory random-access readout
//   mem_wptr                   : next spy memory write address
//   meta_read_addr/enable/data : event list readout, entry {sentinel, addr}
//   meta_wptr                  : next event list write address
//   frozen                     : registered decode of the FROZEN state
//   event_count                : saturating count of captured SOE words
module spy_event_controller
    import spy_pkg::*;
#(
    parameter int         DATAWIDTH = 64,
    parameter int         MEMWIDTH  = 6,
    parameter int         METAWIDTH = 4,
    parameter logic [7:0] SOE_CODE  = SOE_CODE_DEFAULT,
    parameter int         CNTWIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 freeze_req,
    input  logic [MEMWIDTH-1:0]  postfreeze_count,
    input  logic [DATAWIDTH:0]   data_in,
    input  logic                 write_enable_in,
    input  logic [MEMWIDTH-1:0]  read_addr,
    input  logic                 read_enable,
    output logic [DATAWIDTH:0]   data_out,
    output logic [MEMWIDTH-1:0]  mem_wptr,
    input  logic [METAWIDTH-1:0] meta_read_addr,
    input  logic                 meta_read_enable,
    output logic [MEMWIDTH:0]    meta_read_data,
    output logic [METAWIDTH-1:0] meta_wptr,
    output logic                 frozen,
    output logic [CNTWIDTH-1:0]  event_count
);

    localparam int SENT_BIT = meta_sentinel_bit(MEMWIDTH);
    localparam logic [MEMWIDTH-1:0] LAST_ADDR = {MEMWIDTH{1'b1}};

    state_t state, state_next, ret_state, ret_next, mode, target;

    logic                freeze_q;
    logic                freeze_rise;
    logic [MEMWIDTH-1:0] remain, remain_next;

    logic accept, is_soe, is_wrap, new_soe, new_wrap;

    // Event list push staging: one entry per cycle, written one edge later.
    logic                push_vld, push_vld_next;
    logic [MEMWIDTH:0]   push_entry, push_entry_next;
    logic                pending_sent, pending_sent_next;
    logic                pending_soe, pending_soe_next;
    logic [MEMWIDTH-1:0] pending_addr, pending_addr_next;

    function automatic logic [MEMWIDTH:0] soe_entry(input logic [MEMWIDTH-1:0] a);
        logic [MEMWIDTH:0] e;
        e = '0;
        e[META_ADDR_LSB +: MEMWIDTH] = a;
        return e;
    endfunction

    function automatic logic [MEMWIDTH:0] sent_entry();
        logic [MEMWIDTH:0] e;
        e = '0;
        e[SENT_BIT] = 1'b1;
        return e;
    endfunction

    always_comb begin
        accept      = write_enable_in &&
                      (state == ST_RUN || state == ST_ARMED || state == ST_LOOP_MARK);
        is_soe      = data_in[DATAWIDTH] && (data_in[DATAWIDTH-1 -: 8] == SOE_CODE);
        is_wrap     = (mem_wptr == LAST_ADDR);
        new_soe     = accept && is_soe;
        new_wrap    = accept && is_wrap;
        freeze_rise = freeze_req && !freeze_q;
    end

    // Next-state logic. LOOP_MARK behaves like the mode it came from
    // (RUN or ARMED), so writes, decrements and freeze edges are all
    // evaluated against that mode; only the state label differs.
    always_comb begin
        state_next  = state;
        ret_next    = ret_state;
        remain_next = remain;
        mode        = (state == ST_LOOP_MARK) ? ret_state : state;
        target      = mode;
        case (state)
            ST_IDLE:   state_next = ST_RUN;
            ST_FROZEN: if (!freeze_req) state_next = ST_RUN;
            default: begin
                if (mode == ST_RUN) begin
                    if (freeze_rise) begin
                        if (postfreeze_count == '0) begin
                            target = ST_FROZEN;
                        end else begin
                            target      = ST_ARMED;
                            remain_next = postfreeze_count;
                        end
                    end
                end else if (accept) begin
                    remain_next = remain - MEMWIDTH'(1);
                    if (remain == MEMWIDTH'(1)) target = ST_FROZEN;
                end
                // An SOE on the wrap write needs a spare cycle for the
                // sentinel. When capture stops on that write, FROZEN
                // still drains the pending sentinel.
                if (new_soe && new_wrap && target != ST_FROZEN) begin
                    state_next = ST_LOOP_MARK;
                    ret_next   = target;
                end else begin
                    state_next = target;
                end
            end
        endcase
    end

    // Push arbitration: deferred sentinel first, then a deferred SOE, then
    // whatever the current write produces. A new SOE that loses arbitration
    // becomes the next pending SOE.
    always_comb begin
        push_vld_next     = 1'b0;
        push_entry_next   = '0;
        pending_sent_next = pending_sent;
        pending_soe_next  = pending_soe;
        pending_addr_next = pending_addr;
        if (pending_sent) begin
            push_vld_next     = 1'b1;
            push_entry_next   = sent_entry();
            pending_sent_next = 1'b0;
            if (new_soe) begin
                pending_soe_next  = 1'b1;
                pending_addr_next = mem_wptr;
            end
        end else if (pending_soe) begin
            push_vld_next     = 1'b1;
            push_entry_next   = soe_entry(pending_addr);
            pending_soe_next  = new_soe;
            pending_sent_next = new_wrap;
            if (new_soe) pending_addr_next = mem_wptr;
        end else if (new_soe) begin
            push_vld_next     = 1'b1;
            push_entry_next   = soe_entry(mem_wptr);
            pending_sent_next = new_wrap;
        end else if (new_wrap) begin
            push_vld_next   = 1'b1;
            push_entry_next = sent_entry();
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ret_state    <= ST_RUN;
            remain       <= '0;
            freeze_q     <= 1'b0;
            mem_wptr     <= '0;
            meta_wptr    <= '0;
            push_vld     <= 1'b0;
            push_entry   <= '0;
            pending_sent <= 1'b0;
            pending_soe  <= 1'b0;
            pending_addr <= '0;
            frozen       <= 1'b0;
            event_count  <= '0;
        end else begin
            state        <= state_next;
            ret_state    <= ret_next;
            remain       <= remain_next;
            freeze_q     <= freeze_req;
            push_vld     <= push_vld_next;
            push_entry   <= push_entry_next;
            pending_sent <= pending_sent_next;
            pending_soe  <= pending_soe_next;
            pending_addr <= pending_addr_next;
            frozen       <= (state == ST_FROZEN);
            if (accept) mem_wptr <= mem_wptr + MEMWIDTH'(1);
            if (push_vld) meta_wptr <= meta_wptr + METAWIDTH'(1);
            if (new_soe && event_count != {CNTWIDTH{1'b1}})
                event_count <= event_count + CNTWIDTH'(1);
        end
    end

    spy_ram #(.WIDTH(DATAWIDTH + 1), .ADDRWIDTH(MEMWIDTH)) data_ram (
        .clock        (clock),
        .reset        (reset),
        .write_enable (accept),
        .write_addr   (mem_wptr),
        .write_data   (data_in),
        .read_enable  (read_enable),
        .read_addr    (read_addr),
        .read_data    (data_out)
    );

    spy_ram #(.WIDTH(MEMWIDTH + 1), .ADDRWIDTH(METAWIDTH)) meta_ram (
        .clock        (clock),
        .reset        (reset),
        .write_enable (push_vld),
        .write_addr   (meta_wptr),
        .write_data   (push_entry),
        .read_enable  (meta_read_enable),
        .read_addr    (meta_read_addr),
        .read_data    (meta_read_data)
    );

endmodule

// File: tb/tb_spy_event_controller.sv
// Scoreboard bench for spy_event_controller: stimulus pushes expected
// read data / status values into queues, a negedge monitor pops and compares.
module tb_spy_event_controller;

    localparam int DW = 64, MW = 6, XW = 4, CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          freeze_req = 1'b0;
    logic [MW-1:0] postfreeze_count = '0;
    logic [DW:0]   data_in = '0;
    logic          write_enable_in = 1'b0;
    logic [MW-1:0] read_addr = '0;
    logic          read_enable = 1'b0;
    logic [DW:0]   data_out;
    logic [MW-1:0] mem_wptr;
    logic [XW-1:0] meta_read_addr = '0;
    logic          meta_read_enable = 1'b0;
    logic [MW:0]   meta_read_data;
    logic [XW-1:0] meta_wptr;
    logic          frozen;
    logic [CW-1:0] event_count;

    always #5 clock = ~clock;

    spy_event_controller dut (
        .clock            (clock),
        .reset            (reset),
        .freeze_req       (freeze_req),
        .postfreeze_count (postfreeze_count),
        .data_in          (data_in),
        .write_enable_in  (write_enable_in),
        .read_addr        (read_addr),
        .read_enable      (read_enable),
        .data_out         (data_out),
        .mem_wptr         (mem_wptr),
        .meta_read_addr   (meta_read_addr),
        .meta_read_enable (meta_read_enable),
        .meta_read_data   (meta_read_data),
        .meta_wptr        (meta_wptr),
        .frozen           (frozen),
        .event_count      (event_count)
    );

    typedef struct packed {
        logic [3:0]  kind;   // 0 mem_wptr 1 meta_wptr 2 event_count 3 frozen 4 data_out 5 meta_read_data
        logic [DW:0] exp;
    } st_t;

    logic [DW:0] dq[$];
    logic [MW:0] mq[$];
    st_t         sq[$];
    logic [DW:0] mdl [64];
    int          ewp = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done = 1'b0;
    logic        rd_q = 1'b0;
    logic        mrd_q = 1'b0;

    function automatic logic [DW:0] nw(input int i);
        return {1'b0, 64'hA5A5_0000_0000_0000 | 64'(i)};
    endfunction

    function automatic logic [DW:0] sw(input int i);
        return {1'b1, 8'hB0, 56'(i)};
    endfunction

    function automatic string kname(input logic [3:0] k);
        case (k)
            4'd0: return "mem_wptr";
            4'd1: return "meta_wptr";
            4'd2: return "event_count";
            4'd3: return "frozen";
            4'd4: return "data_out";
            default: return "meta_read_data";
        endcase
    endfunction

    function automatic void cmp(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    always @(posedge clock) begin
        rd_q  <= read_enable;
        mrd_q <= meta_read_enable;
    end

    // Monitor: read responses appear one edge after the strobe.
    always @(negedge clock) begin
        if (rd_q) begin
            if (dq.size() == 0) cmp("data_read_unexpected", data_out, '0);
            else cmp("data_read", data_out, dq.pop_front());
        end
        if (mrd_q) begin
            if (mq.size() == 0) cmp("meta_read_unexpected", {58'd0, meta_read_data}, '0);
            else cmp("meta_read", {58'd0, meta_read_data}, {58'd0, mq.pop_front()});
        end
        while (sq.size() > 0) begin
            st_t s;
            logic [DW:0] act;
            s = sq.pop_front();
            case (s.kind)
                4'd0: act = {59'd0, mem_wptr};
                4'd1: act = {61'd0, meta_wptr};
                4'd2: act = {49'd0, event_count};
                4'd3: act = {64'd0, frozen};
                4'd4: act = data_out;
                default: act = {58'd0, meta_read_data};
            endcase
            cmp(kname(s.kind), act, s.exp);
        end
        if (done) begin
            cmp("queue_drain", (DW+1)'(dq.size() + mq.size()), '0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input int k, input longint e);
        st_t s;
        s.kind = 4'(k);
        s.exp  = (DW+1)'(e);
        sq.push_back(s);
    endtask

    task automatic wr(input logic [DW:0] d, input bit acc);
        data_in = d;
        write_enable_in = 1'b1;
        if (acc) begin
            mdl[ewp] = d;
            ewp = (ewp + 1) % 64;
        end
        tick();
        write_enable_in = 1'b0;
    endtask

    task automatic rd(input int a);
        read_addr = MW'(a);
        read_enable = 1'b1;
        dq.push_back(mdl[a]);
        tick();
        read_enable = 1'b0;
    endtask

    task automatic mrd(input int a, input logic [MW:0] e);
        meta_read_addr = XW'(a);
        meta_read_enable = 1'b1;
        mq.push_back(e);
        tick();
        meta_read_enable = 1'b0;
    endtask

    task automatic chk_reset();
        chk(0, 0); chk(1, 0); chk(2, 0); chk(3, 0); chk(4, 0); chk(5, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        chk_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        tick(); tick();

        // Plain capture
        for (int i = 0; i < 10; i++) wr(nw(i), 1'b1);
        chk(0, 10); chk(1, 0); chk(2, 0);
        rd(3);

        // SOE at 10, decoys that are not SOE, SOE on the wrap write,
        // then an SOE at 0 issued during LOOP_MARK
        wr(sw(10), 1'b1);
        for (int i = 11; i < 20; i++) wr(nw(i), 1'b1);
        wr({1'b1, 8'hB1, 56'd20}, 1'b1);
        wr({1'b0, 8'hB0, 56'd21}, 1'b1);
        for (int i = 22; i < 63; i++) wr(nw(i), 1'b1);
        chk(1, 1); chk(2, 1);
        wr(sw(63), 1'b1);
        chk(0, 0); chk(1, 1);
        wr(sw(64), 1'b1);
        chk(1, 2);
        tick();
        chk(1, 3);
        tick();
        chk(1, 4); chk(2, 3); chk(0, 1);

        // Wrap without SOE
        for (int i = 1; i < 64; i++) wr(nw(100 + i), 1'b1);
        tick();
        chk(1, 5); chk(0, 0); chk(2, 3);
        mrd(0, 7'h0A);
        mrd(1, 7'h3F);
        mrd(2, 7'h40);
        mrd(3, 7'h00);
        mrd(4, 7'h40);
        rd(63);
        rd(0);

        // Post-freeze window of 4 words
        postfreeze_count = 6'd4;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) freeze_req = 1'b1;
            wr(nw(200 + k), k <= 6);
        end
        chk(0, 7); chk(3, 1);
        wr(nw(210), 1'b0);
        wr(nw(211), 1'b0);
        chk(0, 7); chk(1, 5);
        rd(6);
        rd(7);

        // Unfreeze: capture resumes at the retained pointer
        freeze_req = 1'b0;
        tick(); tick();
        chk(3, 0);
        wr(nw(300), 1'b1);
        chk(0, 8);
        rd(7);

        // Zero-length window: the write on the request cycle still lands
        postfreeze_count = 6'd0;
        freeze_req = 1'b1;
        wr(nw(301), 1'b1);
        wr(nw(302), 1'b0);
        tick(); tick();
        chk(0, 9); chk(3, 1);
        freeze_req = 1'b0;
        tick(); tick();

        // Reset in the middle of ARMED
        postfreeze_count = 6'd10;
        freeze_req = 1'b1;
        wr(nw(303), 1'b1);
        wr(nw(304), 1'b1);
        wr(nw(305), 1'b1);
        rd(10);
        chk(0, 12);
        tick();
        #1 reset = 1'b0;
        chk_reset();
        @(posedge clock);
        #2 freeze_req = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        ewp = 0;
        tick(); tick();
        wr(nw(400), 1'b1);
        chk(0, 1); chk(1, 0); chk(3, 0);
        rd(0);
        tick();
        done = 1'b1;
    end

endmodule

// File: doc/spy_event_controller.md
# spy_event_controller

Parametrised spy-buffer controller: captures a tagged data stream into a circular spy memory and keeps an event list of start-of-event (SOE) addresses plus wrap sentinels. It adds two capabilities: a programmable post-freeze capture window, and correct handling of an SOE write that coincides with a memory wrap. It sits between a pipeline tap point and the spy readout logic; readout is by random-access address on both memories.

## Interface
- DATAWIDTH, 64: payload width; data words carry one extra metadata bit, so DATAWIDTH+1 wide.
- MEMWIDTH, 6: spy memory address width; depth is 2**MEMWIDTH, minimum 2.
- METAWIDTH, 4: event list address width; depth is 2**METAWIDTH.
- SOE_CODE, 8'hB0: SOE marker, compared against data_in[DATAWIDTH-1:DATAWIDTH-8].
- CNTWIDTH, 16: event counter width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- freeze_req  in  1  level; request to stop capture.
- postfreeze_count  in  MEMWIDTH  number of further words to capture after the freeze request; sampled on the freeze_req rising edge.
- data_in  in  DATAWIDTH+1  bit DATAWIDTH is the metadata flag.
- write_enable_in  in  1  data_in valid this cycle.
- read_addr  in  MEMWIDTH  spy memory read address.
- read_enable  in  1  spy memory read strobe.
- data_out  out  DATAWIDTH+1  spy memory read data.
- mem_wptr  out  MEMWIDTH  next spy memory write address.
- meta_read_addr  in  METAWIDTH  event list read address.
- meta_read_enable  in  1  event list read strobe.
- meta_read_data  out  MEMWIDTH+1  entry format {sentinel, addr}.
- meta_wptr  out  METAWIDTH  next event list write address.
- frozen  out  1  high while in FROZEN.
- event_count  out  CNTWIDTH  SOE words captured since reset; saturates.

## Operation
- SOE: data_in[DATAWIDTH]==1 and data_in[DATAWIDTH-1:DATAWIDTH-8]==SOE_CODE.
- Accepted write: write_enable_in is high and state is RUN, ARMED or LOOP_MARK. The write goes to mem_wptr, then mem_wptr increments modulo 2**MEMWIDTH.
- Wrap: an accepted write at address 2**MEMWIDTH-1.
- Event list pushes, one per cycle maximum:
  - SOE at address A pushes {0,A}.
  - A wrap pushes {1, all-zero}.
  - SOE and wrap on the same write: push {0,A} first, then {1,0} in the following cycle via LOOP_MARK.
- SOE accepted during LOOP_MARK: set pending_soe with its address and push it in the next cycle. This cannot chain, because wraps are at least 2**MEMWIDTH writes apart.
- The event list wraps silently modulo 2**METAWIDTH.
- States:
  - IDLE: entered on reset; next cycle goes to RUN.
  - RUN: on freeze_req rising edge, go to FROZEN if postfreeze_count==0, otherwise load remain=postfreeze_count and go to ARMED.
  - ARMED: each accepted write decrements remain; the write that takes remain to 0 moves the state to FROZEN.
  - LOOP_MARK: one cycle, then returns to the state it came from (RUN or ARMED). In the ARMED case this includes the decrement if the state is left in that cycle, and it goes to FROZEN if remain hits 0.
  - FROZEN: no writes and no pushes, except a pending sentinel or pending_soe, which is still pushed. freeze_req low goes to RUN; pointers are retained.
- Reads are allowed in every state and never disturb capture.
- event_count increments on each accepted SOE and saturates at all-ones.

## Timing
- Reset values: data_out=0, mem_wptr=0, meta_read_data=0, meta_wptr=0, frozen=0, event_count=0, state=IDLE, pending flags=0.
- Reset is asynchronous and may assert mid-capture. Memory contents are undefined after reset; only pointers and registers clear.
- Write latency: data is in memory and mem_wptr updated at the clock edge after acceptance.
- Event list entry for SOE: written one edge after the data write; meta_wptr advances at the same edge. The deferred sentinel lands one edge later.
- Read latency: 1 cycle from a read_enable edge to data_out or meta_read_data. The outputs hold their value when the strobe is low.
- Freeze edge detection uses a registered freeze_req, so FROZEN with postfreeze_count==0 is entered 1 cycle after the rising edge. A write in that same cycle is still accepted.
- frozen is asserted in the cycle after FROZEN is entered; it is a registered state decode.

## Structure
- Package spy_pkg holds SOE_CODE default, the state encoding (IDLE, RUN, ARMED, LOOP_MARK, FROZEN) and the meta entry field offsets.
- Sub-module spy_ram is a simple dual-port RAM (write port plus registered read port), parametrised by width and address width. It is instantiated twice: for the spy data and for the event list.

## Test plan
- Write 10 non-SOE words after reset -> mem_wptr=10, meta_wptr=0, event_count=0, read_addr=3 returns the 4th word next cycle.
- With MEMWIDTH=6, SOE at address 5 -> event list entry 0 = {0,5}; wrap after 64 writes -> entry 1 = {1,0}.
- SOE exactly at address 63 -> entries {0,63} then {1,0} on consecutive edges; SOE at address 0 during LOOP_MARK -> {0,0} pushed the next cycle, no loss.
- postfreeze_count=4, freeze_req rises, write every cycle -> exactly 4 more words captured, frozen=1, mem_wptr stable while writes continue.
- In FROZEN, drop freeze_req -> RUN; the next write lands at the retained mem_wptr.
- Assert reset mid-ARMED -> all outputs return to reset values immediately; capture resumes at address 0 after release.
